// File: rtl/bpi_flash_pkg.sv
// Shared encodings for the BPI flash command sequencer: op codes, FSM states
// and the Intel/Micron-style command bytes written to the flash.
package bpi_flash_pkg;

  typedef enum logic [1:0] {
    OP_PROGRAM = 2'd0,
    OP_ERASE   = 2'd1,
    OP_UNLOCK  = 2'd2,
    OP_RSVD    = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR1,
    ST_WR2,
    ST_TO_RD,
    ST_POLL_REQ,
    ST_POLL_WAIT,
    ST_TO_WR,
    ST_CLR,
    ST_ARRAY,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_PROGRAM    = 8'h40;
  localparam logic [7:0] CMD_ERASE      = 8'h20;
  localparam logic [7:0] CMD_CONFIRM    = 8'hD0;
  localparam logic [7:0] CMD_UNLOCK     = 8'h60;
  localparam logic [7:0] CMD_CLR_STATUS = 8'h50;
  localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
  localparam logic [7:0] SR_READY       = 8'h80;

endpackage

// File: rtl/bpi_flash_cmd_seq.sv
// Sequences program / block-erase / block-unlock commands onto a BPI flash
// controller, polls the status register, then restores read-array mode.
module bpi_flash_cmd_seq
  import bpi_flash_pkg::*;
#(
  parameter int C_MEM_WIDTH  = 16,
  parameter int C_ADDR_WIDTH = 26,
  parameter int C_POLL_LIMIT = 4194304
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              cmd_op,
  input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_MEM_WIDTH-1:0]  cmd_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [7:0]              rsp_status,
  output logic                    rsp_error,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    mode,
  output logic [C_MEM_WIDTH-1:0]  wr_tdata,
  output logic [C_ADDR_WIDTH-1:0] wr_tdest,
  output logic                    wr_tvalid,
  input  logic                    wr_tready,
  output logic [C_ADDR_WIDTH-1:0] rd_tdata,
  output logic                    rd_tvalid,
  input  logic                    rd_tready,
  input  logic [C_MEM_WIDTH-1:0]  rdata,
  input  logic                    rdata_valid,
  output logic [3:0]              dbg_state
);

  localparam int POLL_W = $clog2(C_POLL_LIMIT + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(C_POLL_LIMIT - 1);

  // All streams use valid/ready: a beat transfers on the rising edge where both
  // are high; valid and payload never change while valid is high and ready low.
  state_t                  state, state_n;
  op_t                     op_q;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_MEM_WIDTH-1:0]  data_q;
  logic [7:0]              status_q;
  logic                    err_q;
  logic [POLL_W-1:0]       poll_cnt;
  logic                    mode_q, mode_n;
  logic [1:0]              settle;
  logic                    run_q;
  logic                    accept, wr_fire, rd_fire, last_poll;
  logic                    unused_rdata;

  assign accept       = cmd_valid & cmd_ready;
  assign wr_fire      = wr_tvalid & wr_tready;
  assign rd_fire      = rd_tvalid & rd_tready;
  assign last_poll    = (poll_cnt == POLL_LAST);
  assign unused_rdata = ^rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (accept) state_n = (op_t'(cmd_op) == OP_RSVD) ? ST_RESP : ST_WR1;
      ST_WR1:       if (wr_fire) state_n = ST_WR2;
      ST_WR2:       if (wr_fire) state_n = (op_q == OP_UNLOCK) ? ST_TO_WR : ST_TO_RD;
      ST_TO_RD:     if (settle == 2'd0) state_n = ST_POLL_REQ;
      ST_POLL_REQ:  if (rd_fire) state_n = ST_POLL_WAIT;
      ST_POLL_WAIT: if (rdata_valid) state_n = (rdata[7] || last_poll) ? ST_TO_WR : ST_POLL_REQ;
      ST_TO_WR:     if (settle == 2'd0) state_n = ST_CLR;
      ST_CLR:       if (wr_fire) state_n = ST_ARRAY;
      ST_ARRAY:     if (wr_fire) state_n = ST_RESP;
      ST_RESP:      if (rsp_ready) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
    // Bus direction follows the state being entered; RESP keeps whatever it had.
    mode_n = mode_q;
    case (state_n)
      ST_WR1, ST_WR2, ST_TO_WR, ST_CLR, ST_ARRAY: mode_n = 1'b1;
      ST_RESP:                                    mode_n = mode_q;
      default:                                    mode_n = 1'b0;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == ST_IDLE) && run_q;
    rsp_valid  = (state == ST_RESP);
    rsp_status = status_q;
    rsp_error  = err_q;
    mode       = mode_q;
    dbg_state  = state;
    wr_tvalid  = 1'b0;
    wr_tdata   = '0;
    wr_tdest   = '0;
    rd_tvalid  = 1'b0;
    rd_tdata   = '0;
    case (state)
      ST_WR1: begin
        wr_tvalid = (settle == 2'd0);
        wr_tdest  = addr_q;
        case (op_q)
          OP_ERASE:  wr_tdata = C_MEM_WIDTH'(CMD_ERASE);
          OP_UNLOCK: wr_tdata = C_MEM_WIDTH'(CMD_UNLOCK);
          default:   wr_tdata = C_MEM_WIDTH'(CMD_PROGRAM);
        endcase
      end
      ST_WR2: begin
        wr_tvalid = (settle == 2'd0);
        wr_tdest  = addr_q;
        wr_tdata  = (op_q == OP_PROGRAM) ? data_q : C_MEM_WIDTH'(CMD_CONFIRM);
      end
      ST_CLR: begin
        wr_tvalid = (settle == 2'd0);
        wr_tdest  = addr_q;
        wr_tdata  = C_MEM_WIDTH'(CMD_CLR_STATUS);
      end
      ST_ARRAY: begin
        wr_tvalid = (settle == 2'd0);
        wr_tdest  = addr_q;
        wr_tdata  = C_MEM_WIDTH'(CMD_READ_ARRAY);
      end
      ST_POLL_REQ: begin
        rd_tvalid = (settle == 2'd0);
        rd_tdata  = addr_q;
      end
      default: ;
    endcase
  end

  // settle: 2 idle cycles after a bus turnaround, 1 idle cycle after each write beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_PROGRAM;
      addr_q   <= '0;
      data_q   <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
      poll_cnt <= '0;
      mode_q   <= 1'b0;
      settle   <= 2'd0;
      run_q    <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      mode_q <= mode_n;
      if (mode_n != mode_q)   settle <= 2'd2;
      else if (wr_fire)       settle <= 2'd1;
      else if (settle != 2'd0) settle <= settle - 2'd1;
      if (accept) begin
        op_q     <= op_t'(cmd_op);
        addr_q   <= cmd_addr;
        data_q   <= cmd_data;
        status_q <= '0;
        err_q    <= (op_t'(cmd_op) == OP_RSVD);
        poll_cnt <= '0;
      end
      if (state == ST_WR2 && wr_fire && op_q == OP_UNLOCK) begin
        status_q <= SR_READY;
        err_q    <= 1'b0;
      end
      if (state == ST_POLL_WAIT && rdata_valid) begin
        status_q <= rdata[7:0];
        poll_cnt <= poll_cnt + POLL_W'(1);
        if (rdata[7])       err_q <= |rdata[5:1];
        else if (last_poll) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bpi_flash_cmd_seq.sv
// Bench for bpi_flash_cmd_seq: directed vector table, mid-poll reset, then
// random commands against a transaction-level model of the flash sequence.
module tb_bpi_flash_cmd_seq;
  import bpi_flash_pkg::*;

  localparam int MW = 16;
  localparam int AW = 26;
  localparam int LIMIT = 4;
  localparam int LW = AW + MW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [MW-1:0] cmd_data = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    rsp_status;
  logic          rsp_error;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          mode;
  logic [MW-1:0] wr_tdata;
  logic [AW-1:0] wr_tdest;
  logic          wr_tvalid;
  logic          wr_tready = 1'b0;
  logic [AW-1:0] rd_tdata;
  logic          rd_tvalid;
  logic          rd_tready = 1'b0;
  logic [MW-1:0] rdata = '0;
  logic          rdata_valid = 1'b0;
  logic [3:0]    dbg_state;

  always #5 clk = ~clk;

  bpi_flash_cmd_seq #(.C_MEM_WIDTH(MW), .C_ADDR_WIDTH(AW), .C_POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_status(rsp_status), .rsp_error(rsp_error), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .mode(mode), .wr_tdata(wr_tdata), .wr_tdest(wr_tdest), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
    .rdata(rdata), .rdata_valid(rdata_valid), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic [LW-1:0] wr_log[$];
  logic [LW-1:0] exp_q[$];
  logic [7:0]    sr_script[$];
  int            rd_count = 0;
  logic [AW-1:0] cur_addr = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sr_at(input int idx);
    if (sr_script.size() == 0) return 8'h80;
    return (idx < sr_script.size()) ? sr_script[idx] : sr_script[sr_script.size()-1];
  endfunction

  // Flash side: random ready, status reads answered from sr_script, protocol checks.
  logic          prev_wv = 0, prev_wr = 0, prev_rv = 0, prev_rr = 0, prev_mode = 0;
  logic [MW-1:0] prev_wd = '0;
  logic [AW-1:0] prev_wdest = '0, prev_rdt = '0;
  int            mode_age = 0;
  logic          pend = 0;
  int            dly = 0;
  logic [7:0]    pend_sr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wr_tready = 0; rd_tready = 0; rdata_valid = 0; rdata = '0; pend = 0;
      prev_wv = 0; prev_wr = 0; prev_rv = 0; prev_rr = 0; prev_mode = 0; mode_age = 0;
    end else begin
      if (mode === prev_mode) mode_age++;
      else mode_age = 0;
      if (wr_tvalid || rd_tvalid) check("wr_rd_exclusive", 64'(wr_tvalid & rd_tvalid), 0);
      if (prev_wv && !prev_wr) check("wr_hold", {wr_tvalid, wr_tdest, wr_tdata}, {1'b1, prev_wdest, prev_wd});
      if (prev_wv && prev_wr) check("wr_release", 64'(wr_tvalid), 0);
      if (wr_tvalid && !prev_wv) check("wr_mode_settled", {mode, mode_age >= 2}, 2'b11);
      if (prev_rv && !prev_rr) check("rd_hold", {rd_tvalid, rd_tdata}, {1'b1, prev_rdt});
      if (prev_rv && prev_rr) check("rd_release", 64'(rd_tvalid), 0);
      if (rd_tvalid && !prev_rv) check("rd_mode_settled", {mode, mode_age >= 2}, 2'b01);
      rdata_valid = 0;
      rdata = MW'($urandom);
      if (pend) begin
        if (dly == 0) begin
          rdata_valid = 1;
          rdata = {8'($urandom), pend_sr};
          pend = 0;
        end else dly--;
      end
      wr_tready = ($urandom_range(0, 3) != 0);
      rd_tready = ($urandom_range(0, 3) != 0);
      if (wr_tvalid && wr_tready) wr_log.push_back({wr_tdest, wr_tdata});
      if (rd_tvalid && rd_tready) begin
        check("rd_addr", 64'(rd_tdata), 64'(cur_addr));
        pend_sr = sr_at(rd_count);
        rd_count++;
        pend = 1;
        dly = $urandom_range(0, 2);
      end
      prev_wv = wr_tvalid; prev_wr = wr_tready; prev_wd = wr_tdata; prev_wdest = wr_tdest;
      prev_rv = rd_tvalid; prev_rr = rd_tready; prev_rdt = rd_tdata; prev_mode = mode;
    end
  end

  task automatic issue_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [MW-1:0] data);
    int t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    check("cmd_ready_wait", 64'(cmd_ready), 1);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_data = MW'($urandom);
  endtask

  task automatic finish_cmd(input int hold, input logic illegal, output logic [7:0] st, output logic err);
    int t = 0;
    while (!rsp_valid && t < 3000) begin @(negedge clk); t++; end
    check("rsp_valid_wait", 64'(rsp_valid), 1);
    if (illegal) check("illegal_latency", 64'(t), 0);
    st = rsp_status; err = rsp_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, rsp_status, rsp_error, cmd_ready}, {1'b1, st, err, 1'b0});
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_done_idle_mode", {rsp_valid, mode}, 0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(wr_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) check({tag, "_write"}, 64'(wr_log[i]), 64'(exp_q[i]));
    wr_log.delete();
    exp_q.delete();
  endtask

  // Reference: command bytes per op, then reads until ready or limit, then clear + read-array.
  task automatic model(input logic [1:0] op, input logic [AW-1:0] addr, input logic [MW-1:0] data,
                       output logic [7:0] st, output logic err, output int reads);
    reads = 0; st = 8'h00; err = 1'b1;
    case (op)
      2'd0: begin exp_q.push_back({addr, 16'h0040}); exp_q.push_back({addr, data}); end
      2'd1: begin exp_q.push_back({addr, 16'h0020}); exp_q.push_back({addr, 16'h00D0}); end
      2'd2: begin exp_q.push_back({addr, 16'h0060}); exp_q.push_back({addr, 16'h00D0}); end
      default: ;
    endcase
    if (op == 2'd2) begin
      st = 8'h80; err = 1'b0;
    end else if (op != 2'd3) begin
      for (int n = 1; n <= LIMIT; n++) begin
        st = sr_at(n - 1);
        reads = n;
        if (st[7]) begin err = |st[5:1]; break; end
      end
    end
    if (op != 2'd3) begin
      exp_q.push_back({addr, 16'h0050});
      exp_q.push_back({addr, 16'h00FF});
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
    logic [7:0]    sr[4];
    int            nsr;
    int            hold;
    logic          wr;
    logic [MW-1:0] w1, w2;
    int            reads;
    logic [7:0]    st;
    logic          err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] st;
    logic err;
    logic [7:0] m_st;
    logic m_err;
    int m_reads;
    int t;

    vecs[0] = '{op: 2'd0, addr: 26'h100, data: 16'hBEEF, sr: '{8'h00, 8'h00, 8'h80, 8'h80}, nsr: 3, hold: 0,
                wr: 1'b1, w1: 16'h0040, w2: 16'hBEEF, reads: 3, st: 8'h80, err: 1'b0};
    vecs[1] = '{op: 2'd1, addr: 26'h20000, data: 16'h0000, sr: '{8'hA0, 8'h00, 8'h00, 8'h00}, nsr: 1, hold: 2,
                wr: 1'b1, w1: 16'h0020, w2: 16'h00D0, reads: 1, st: 8'hA0, err: 1'b1};
    vecs[2] = '{op: 2'd2, addr: 26'h40000, data: 16'h1111, sr: '{8'h00, 8'h00, 8'h00, 8'h00}, nsr: 1, hold: 0,
                wr: 1'b1, w1: 16'h0060, w2: 16'h00D0, reads: 0, st: 8'h80, err: 1'b0};
    vecs[3] = '{op: 2'd0, addr: 26'h3FFFFFF, data: 16'h1234, sr: '{8'h00, 8'h00, 8'h00, 8'h00}, nsr: 1, hold: 1,
                wr: 1'b1, w1: 16'h0040, w2: 16'h1234, reads: 4, st: 8'h00, err: 1'b1};
    vecs[4] = '{op: 2'd3, addr: 26'h555, data: 16'hFFFF, sr: '{8'h80, 8'h00, 8'h00, 8'h00}, nsr: 1, hold: 10,
                wr: 1'b0, w1: 16'h0000, w2: 16'h0000, reads: 0, st: 8'h00, err: 1'b1};
    vecs[5] = '{op: 2'd1, addr: 26'h0, data: 16'h0000, sr: '{8'h82, 8'h00, 8'h00, 8'h00}, nsr: 1, hold: 0,
                wr: 1'b1, w1: 16'h0020, w2: 16'h00D0, reads: 1, st: 8'h82, err: 1'b1};
    vecs[6] = '{op: 2'd0, addr: 26'h7, data: 16'h00FF, sr: '{8'h01, 8'hC0, 8'h00, 8'h00}, nsr: 2, hold: 0,
                wr: 1'b1, w1: 16'h0040, w2: 16'h00FF, reads: 2, st: 8'hC0, err: 1'b0};

    // Reset and release
    repeat (3) @(negedge clk);
    check("reset_ctrl", {cmd_ready, rsp_valid, rsp_status, rsp_error, mode, wr_tvalid, rd_tvalid}, 0);
    check("reset_data", {wr_tdata, wr_tdest}, 0);
    rst_n = 1;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      sr_script.delete();
      for (int k = 0; k < vecs[i].nsr; k++) sr_script.push_back(vecs[i].sr[k]);
      rd_count = 0;
      cur_addr = vecs[i].addr;
      if (vecs[i].wr) begin
        exp_q.push_back({vecs[i].addr, vecs[i].w1});
        exp_q.push_back({vecs[i].addr, vecs[i].w2});
        exp_q.push_back({vecs[i].addr, 16'h0050});
        exp_q.push_back({vecs[i].addr, 16'h00FF});
      end
      issue_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
      finish_cmd(vecs[i].hold, vecs[i].op == 2'd3, st, err);
      check("vec_status", 64'(st), 64'(vecs[i].st));
      check("vec_error", 64'(err), 64'(vecs[i].err));
      check("vec_reads", 64'(rd_count), 64'(vecs[i].reads));
      compare_writes("vec");
    end

    // Reset while waiting on a status read
    sr_script.delete(); sr_script.push_back(8'h00);
    rd_count = 0; cur_addr = 26'h2A0;
    issue_cmd(2'd0, 26'h2A0, 16'h5A5A);
    t = 0;
    while (dbg_state != 4'(ST_POLL_WAIT) && t < 500) begin @(negedge clk); t++; end
    check("reach_poll_wait", 64'(dbg_state), 64'(4'(ST_POLL_WAIT)));
    rst_n = 0;
    @(negedge clk);
    check("mid_reset_ctrl", {cmd_ready, rsp_valid, rsp_status, rsp_error, mode, wr_tvalid, rd_tvalid}, 0);
    check("mid_reset_wr", {wr_tdata, wr_tdest}, 0);
    check("mid_reset_rd", 64'(rd_tdata), 0);
    check("mid_reset_state", 64'(dbg_state), 64'(4'(ST_IDLE)));
    @(negedge clk);
    rst_n = 1;
    wr_log.delete(); exp_q.delete();
    @(negedge clk);
    check("ready_after_mid_reset", 64'(cmd_ready), 1);
    sr_script.delete(); sr_script.push_back(8'h00); sr_script.push_back(8'h80);
    rd_count = 0; cur_addr = 26'h2A0;
    model(2'd0, 26'h2A0, 16'h5A5A, m_st, m_err, m_reads);
    issue_cmd(2'd0, 26'h2A0, 16'h5A5A);
    finish_cmd(0, 1'b0, st, err);
    check("post_reset_status", 64'(st), 64'(m_st));
    check("post_reset_error", 64'(err), 64'(m_err));
    check("post_reset_reads", 64'(rd_count), 64'(m_reads));
    compare_writes("post_reset");

    // Random commands
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [AW-1:0] addr;
      logic [MW-1:0] data;
      int n;
      op = 2'($urandom_range(0, 3));
      addr = AW'($urandom);
      data = MW'($urandom);
      n = $urandom_range(1, 5);
      sr_script.delete();
      for (int k = 0; k < n - 1; k++) sr_script.push_back(8'($urandom) & 8'h7F);
      if ($urandom_range(0, 3) == 0) sr_script.push_back(8'($urandom) & 8'h7F);
      else sr_script.push_back(8'($urandom) | 8'h80);
      rd_count = 0;
      cur_addr = addr;
      model(op, addr, data, m_st, m_err, m_reads);
      issue_cmd(op, addr, data);
      finish_cmd($urandom_range(0, 3), op == 2'd3, st, err);
      check("rand_status", 64'(st), 64'(m_st));
      check("rand_error", 64'(err), 64'(m_err));
      check("rand_reads", 64'(rd_count), 64'(m_reads));
      compare_writes("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
